// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a bank of transparent-high D latches.
// Optional back-to-back arbitration in the final HOLD cycle: define LATCH_WR_SCHED_B2B_EN.
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// SETUP  | lat_d stable, lat_e low, SETUP_CYC cycles
// ENABLE | one-hot lat_e high, EN_CYC cycles
// HOLD   | lat_e low, lat_d held, HOLD_CYC cycles; ack in last cycle
module latch_wr_sched #(
   parameter int NREQ      = 4,
   parameter int NLAT      = 8,
   parameter int DW        = 8,
   parameter int SETUP_CYC = 1,
   parameter int EN_CYC    = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*$clog2(NLAT)-1:0]  addr,
   input  logic [NREQ*DW-1:0]            wdata,
   output logic [NREQ-1:0]               gnt,
   output logic [NREQ-1:0]               ack,
   output logic                          busy,
   output logic [DW-1:0]                 lat_d,
   output logic [NLAT-1:0]               lat_e
);

   localparam int AW   = $clog2(NLAT);
   localparam int PW   = $clog2(NREQ);
   localparam int CM1  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int CMAX = (CM1 > HOLD_CYC) ? CM1 : HOLD_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ENABLE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win_q;
   logic [AW-1:0]   addr_q;

   logic [NREQ-1:0] arb_req;
   logic            arb_hit;
   logic [PW-1:0]   arb_win;
   logic            start;
   logic [PW-1:0]   next_ptr;
   logic [NLAT-1:0] lat_sel;
   int              idx;

`ifdef LATCH_WR_SCHED_B2B_EN
   // the requester being acked this cycle must not win again immediately
   assign arb_req = (state == ST_HOLD) ? (req & ~gnt) : req;
   assign start   = arb_hit && ((state == ST_IDLE) ||
                                ((state == ST_HOLD) && (cnt == '0)));
`else
   assign arb_req = req;
   assign start   = arb_hit && (state == ST_IDLE);
`endif

   always_comb begin
      arb_hit = 1'b0;
      arb_win = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!arb_hit && arb_req[idx]) begin
            arb_hit = 1'b1;
            arb_win = PW'(idx);
         end
      end
   end

   assign next_ptr = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
   assign lat_sel  = NLAT'(1) << addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         rr_ptr <= '0;
         win_q  <= '0;
         addr_q <= '0;
         gnt    <= '0;
         ack    <= '0;
         busy   <= 1'b0;
         lat_d  <= '0;
         lat_e  <= '0;
      end else begin
         ack <= '0;
         if (start) begin
            state  <= ST_SETUP;
            cnt    <= CW'(SETUP_CYC - 1);
            win_q  <= arb_win;
            addr_q <= addr[int'(arb_win)*AW +: AW];
            lat_d  <= wdata[int'(arb_win)*DW +: DW];
            gnt    <= NREQ'(1) << arb_win;
            busy   <= 1'b1;
         end else begin
            case (state)
               ST_SETUP: begin
                  if (cnt == '0) begin
                     state <= ST_ENABLE;
                     cnt   <= CW'(EN_CYC - 1);
                     lat_e <= lat_sel;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_ENABLE: begin
                  if (cnt == '0) begin
                     state <= ST_HOLD;
                     cnt   <= CW'(HOLD_CYC - 1);
                     lat_e <= '0;
                     if (HOLD_CYC == 1) begin
                        ack    <= gnt;
                        rr_ptr <= next_ptr;
                     end
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (cnt == '0) begin
                     state <= ST_IDLE;
                     gnt   <= '0;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                     // entering the last HOLD cycle
                     if (cnt == CW'(1)) begin
                        ack    <= gnt;
                        rr_ptr <= next_ptr;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: transaction-timeline model for the default instance,
// plus hand-computed checks including a long-phase instance (SETUP 2, EN 4, HOLD 3).
`timescale 1ns/1ps
module tb_latch_wr_sched;
   localparam int NREQ = 4;
   localparam int AW   = 3;
   localparam int DW   = 8;
   localparam int S    = 1;
   localparam int E    = 2;
   localparam int H    = 1;
   localparam int P    = S + E + H;
`ifdef LATCH_WR_SCHED_B2B_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req   = '0;
   logic [11:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  gnt, ack;
   logic        busy;
   logic [7:0]  lat_d, lat_e;

   logic [3:0]  req2   = '0;
   logic [11:0] addr2  = '0;
   logic [31:0] wdata2 = '0;
   logic [3:0]  gnt2, ack2;
   logic        busy2;
   logic [7:0]  lat_d2, lat_e2;

   int vec  = 0;
   int miss = 0;

   always #5 clk = ~clk;

   latch_wr_sched dut (
      .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .busy(busy), .lat_d(lat_d), .lat_e(lat_e)
   );

   latch_wr_sched #(.SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req2), .addr(addr2), .wdata(wdata2),
      .gnt(gnt2), .ack(ack2), .busy(busy2), .lat_d(lat_d2), .lat_e(lat_e2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < NREQ; i++) begin
         if (v == (4'b0001 << i)) return i;
      end
      return 99;
   endfunction

   // Model: a transaction is a start edge plus captured winner/addr/data;
   // every output follows from the offset of the current edge to that start.
   int         cyc      = 0;
   bit         m_active = 1'b0;
   int         m_start  = 0;
   int         m_win    = 0;
   int         m_ptr    = 0;
   int         m_addr   = 0;
   logic [7:0] m_d      = '0;

   always begin : model
      bit         ended;
      int         w;
      logic [3:0] r;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 1'b0;
         m_ptr    = 0;
         m_d      = '0;
      end else begin
         cyc++;
         ended = 1'b0;
         if (m_active && (cyc - m_start == P)) begin
            m_active = 1'b0;
            m_ptr    = (m_win + 1) % NREQ;
            ended    = 1'b1;
         end
         if (!m_active && (!ended || B2B)) begin
            r = req;
            if (ended) r[m_win] = 1'b0;
            w = rr_pick(r, m_ptr);
            if (w >= 0) begin
               m_active = 1'b1;
               m_start  = cyc;
               m_win    = w;
               m_addr   = int'(addr[w*AW +: AW]);
               m_d      = wdata[w*DW +: DW];
            end
         end
      end
   end

   task automatic compare_loop();
      logic [7:0] prev_e = '0;
      logic [3:0] eg, ea;
      logic [7:0] ee;
      logic       eb;
      int         rel;
      forever begin
         @(negedge clk);
         eg = '0; ea = '0; ee = '0; eb = 1'b0;
         if (m_active) begin
            rel = cyc - m_start;
            eg  = 4'b0001 << m_win;
            eb  = 1'b1;
            if (rel >= S && rel < S + E) ee = 8'h01 << m_addr;
            if (rel == P - 1) ea = eg;
         end
         chk("model_gnt",   gnt,   eg);
         chk("model_ack",   ack,   ea);
         chk("model_busy",  busy,  eb);
         chk("model_lat_e", lat_e, ee);
         chk("model_lat_d", lat_d, m_d);
         chk("lat_e_no_gap", (prev_e != 0 && lat_e != 0 && lat_e != prev_e), 0);
         prev_e = lat_e;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin : stim
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      int rec_idx[5];
      int rec_t[5];
      int n_ack;
      fork
         compare_loop();
      join_none

      repeat (2) @(negedge clk);
      chk("rst_gnt2",   gnt2,   4'h0);
      chk("rst_busy2",  busy2,  1'b0);
      chk("rst_lat_e2", lat_e2, 8'h00);
      chk("rst_lat_d2", lat_d2, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // long-phase instance: SETUP 2, EN 4, HOLD 3
      req2 = 4'b0001; addr2[2:0] = 3'd3; wdata2[7:0] = 8'h3C;
      for (int r = 0; r <= 10; r++) begin
         @(negedge clk);
         chk("d2_lat_e", lat_e2, (r >= 2 && r < 6) ? 8'h08 : 8'h00);
         chk("d2_ack",   ack2,   (r == 8) ? 4'b0001 : 4'b0000);
         chk("d2_lat_d", lat_d2, 8'h3C);
         chk("d2_busy",  busy2,  (r < 9));
         if (r == 8) req2 = '0;
      end

      // single write: requester 1, addr 5, data A5
      req = 4'b0010; addr[5:3] = 3'd5; wdata[15:8] = 8'hA5;
      @(negedge clk);
      chk("sw_lat_d", lat_d, 8'hA5);
      chk("sw_gnt",   gnt,   4'b0010);
      chk("sw_busy",  busy,  1'b1);
      chk("sw_lat_e0", lat_e, 8'h00);
      @(negedge clk);
      chk("sw_lat_e1", lat_e, 8'h20);
      @(negedge clk);
      chk("sw_lat_e2", lat_e, 8'h20);
      @(negedge clk);
      chk("sw_lat_e3", lat_e, 8'h00);
      chk("sw_ack",    ack,   4'b0010);
      req = '0;
      @(negedge clk);
      chk("sw_idle_busy", busy, 1'b0);
      chk("sw_idle_ack",  ack,  4'b0000);
      chk("sw_idle_gnt",  gnt,  4'b0000);
      @(negedge clk);

      // requester 2 drops req and changes addr/data during ENABLE
      req = 4'b0100; addr[8:6] = 3'd6; wdata[23:16] = 8'h5A;
      @(negedge clk);
      @(negedge clk);
      req = '0; addr[8:6] = 3'd1; wdata[23:16] = 8'hFF;
      @(negedge clk);
      chk("drop_lat_e", lat_e, 8'h40);
      chk("drop_lat_d", lat_d, 8'h5A);
      @(negedge clk);
      chk("drop_ack", ack, 4'b0100);
      @(negedge clk);
      @(negedge clk);

      // reset during ENABLE of requester 3 (rr_ptr is 3 here)
      req = 4'b1000; addr[11:9] = 3'd2; wdata[31:24] = 8'h77;
      @(negedge clk);
      @(negedge clk);
      chk("abort_pre_lat_e", lat_e, 8'h04);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_lat_e", lat_e, 8'h00);
      chk("abort_gnt",   gnt,   4'b0000);
      chk("abort_busy",  busy,  1'b0);
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // all requesters held high: order must restart from 0
      req   = 4'hF;
      addr  = {3'd7, 3'd0, 3'd3, 3'd1};
      wdata = 32'h4433_2211;
      n_ack = 0;
      for (int c = 0; c < 60 && n_ack < 5; c++) begin
         @(negedge clk);
         if (ack != 4'b0000) begin
            rec_idx[n_ack] = oh_idx(ack);
            rec_t[n_ack]   = c;
            n_ack++;
         end
      end
      req = '0;
      chk("rr_ack_count", n_ack, 5);
      for (int i = 0; i < n_ack; i++) begin
         chk("rr_order", rec_idx[i], exp_ord[i]);
         if (i > 0) chk("rr_period", rec_t[i] - rec_t[i-1], B2B ? 4 : 5);
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/latch_wr_sched.md
# latch_wr_sched

Write scheduler for a bank of level-sensitive D latches (one latch word per address, each with a data input `d` and a transparent-high enable `e`). It arbitrates write requests from several requesters round-robin, captures the winner's address and data, and sequences the latch interface through setup, enable and hold phases. The result is a glitch-free one-hot enable pulse of fixed width, with data held stable around it. It sits between the synchronous requester logic and the latch array.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `NLAT`, 8: number of latch words; power of two, ≥2
- `DW`, 8: latch word width
- `SETUP_CYC`, 1: cycles data is stable before enable rises (≥1)
- `EN_CYC`, 2: cycles enable is high (≥1)
- `HOLD_CYC`, 1: cycles data is stable after enable falls (≥1)

Ports:
- `clk` in 1: the only clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req` in NREQ: per-requester write request, level; held until `ack`
- `addr` in NREQ*log2(NLAT): packed, requester i at bits [i*AW +: AW]
- `wdata` in NREQ*DW: packed, requester i at bits [i*DW +: DW]
- `gnt` out NREQ: one-hot, high for the whole transaction of the winner
- `ack` out NREQ: one-hot, one-cycle pulse on completion
- `busy` out 1: high whenever state ≠ IDLE
- `lat_d` out DW: data to all latch `d` inputs
- `lat_e` out NLAT: one-hot latch enables

## Operation
- FSM states: IDLE, SETUP, ENABLE, HOLD. Phase counter width is ≥ log2 of max(SETUP_CYC, EN_CYC, HOLD_CYC)+1.
- IDLE:
  - If any `req` is set, the round-robin winner is the first set bit at or above `rr_ptr`, wrapping.
  - Register `gnt`, latch the winner's `addr`/`wdata` into internal regs, drive `lat_d`, and go to SETUP.
- SETUP: `lat_e`=0 for SETUP_CYC cycles, then ENABLE.
- ENABLE: `lat_e[addr_q]`=1 for EN_CYC cycles, then HOLD. Only one bit is ever high.
- HOLD: `lat_e`=0 and `lat_d` unchanged for HOLD_CYC cycles. `ack[winner]`=1 in the final HOLD cycle. `rr_ptr` ← winner+1 mod NREQ. Next state is IDLE.
- Outputs and capture:
  - All outputs are registered; `lat_e` comes directly from a flop, with no combinational decode at the output.
  - `lat_d` changes only on the capture edge (IDLE→SETUP).
  - Captured address and data are used for the whole transaction. A requester changing `addr`/`wdata` or dropping `req` mid-transaction has no effect; its `ack` still pulses.
- Requesters other than the winner wait. `req` bits that are not granted are never acked.
- Reset:
  - State IDLE; `gnt`, `ack`, `busy`, `lat_e`, `lat_d` all 0; `rr_ptr`=0.
  - Asserting reset mid-transaction drops `lat_e` immediately (asynchronously). The write is aborted and no `ack` is issued. Latch contents are then unspecified for that address only.

## Timing
- Edge numbering: `req` is sampled high at edge 0 in IDLE.
- Edge 0: `gnt`, `busy`, `lat_d` valid after this edge.
- `lat_e` high after edge SETUP_CYC, low after edge SETUP_CYC+EN_CYC.
- `ack` high from edge SETUP_CYC+EN_CYC+HOLD_CYC−1 for one cycle.
- Edge SETUP_CYC+EN_CYC+HOLD_CYC: IDLE, with `gnt`/`busy` dropping.
- Transaction period is 1+SETUP_CYC+EN_CYC+HOLD_CYC cycles, which is 5 at defaults.
- Simultaneous requests: one grant per transaction, in round-robin order. No requester waits more than NREQ−1 transactions.

## Configuration
- Macro `LATCH_WR_SCHED_B2B_EN`.
- Defined:
  - In the final HOLD cycle the FSM arbitrates as IDLE would. Requests are evaluated with the updated `rr_ptr`, and the acked requester is excluded for that cycle.
  - On a winner it goes directly to SETUP, capturing new data at that edge. IDLE is skipped, so the back-to-back period is SETUP_CYC+EN_CYC+HOLD_CYC (4 at defaults).
  - `busy` stays high across back-to-back transactions.
- Undefined: at least one IDLE cycle always separates transactions.

## Test plan
- Single write, defaults: req[1]=1, addr=5, wdata=0xA5 at edge 0.
  - `lat_d`=0xA5 from edge 0.
  - `lat_e`=0x20 for edges 1–3 only.
  - `ack`=0b0010 in cycle 3–4; IDLE at edge 4.
- All four `req` held high continuously:
  - Grants go 0,1,2,3,0.
  - Periods are 5 cycles, or 4 with `LATCH_WR_SCHED_B2B_EN`.
  - `lat_e` is never high in two consecutive transactions without a low cycle between.
- req[2] dropped and its `addr`/`wdata` changed during ENABLE:
  - `lat_e`/`lat_d` keep the captured values.
  - `ack[2]` still pulses.
- `rst_n` asserted low during ENABLE: `lat_e`, `gnt`, `busy` go 0 without waiting for `clk`; no `ack`; after release, state is IDLE and `rr_ptr`=0.
- EN_CYC=4, SETUP_CYC=2, HOLD_CYC=3:
  - `lat_e` is high exactly 4 cycles starting at edge 2.
  - `ack` is at edge 8.
  - `lat_d` is stable from edge 0 to edge 9.
